reg_alu_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle register-file/ALU datapath.
- Two stages:
  - Issue: register-file read and operand select.
  - Execute (EX): ALU compute, then writeback.
- Adds a forwarding path, an iterative multi-cycle multiplier with a valid/ready stall handshake, and registered result/EQ outputs.
- Sits between the control unit/instruction memory and the PC branch logic in the reduced RISC-V core.

---
 rtl/reg_alu_pipe_if.sv | 29 ++
 rtl/reg_alu_pipe.sv | 136 +++++++++++++
 tb/tb_reg_alu_pipe.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_alu_pipe_if.sv
// rtl/reg_alu_pipe_if.sv - instruction issue and result bus of the pipelined register-file/ALU datapath
interface reg_alu_pipe_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int INSTR_WIDTH   = 32,
   parameter int IMMOP_WIDTH   = 32,
   parameter int CONTROL_WIDTH = 4
) ();
   logic                     valid_in;
   logic                     ready_out;
   logic                     ALUsrc;
   logic [CONTROL_WIDTH-1:0] ALUctrl;
   logic                     RegWrite;
   logic [INSTR_WIDTH-1:0]   instr;
   logic [IMMOP_WIDTH-1:0]   ImmOp;
   logic [DATA_WIDTH-1:0]    result;
   logic                     result_valid;
   logic                     EQ;
   logic [DATA_WIDTH-1:0]    a0;

   modport master (
      output valid_in, ALUsrc, ALUctrl, RegWrite, instr, ImmOp,
      input  ready_out, result, result_valid, EQ, a0
   );

   modport slave (
      input  valid_in, ALUsrc, ALUctrl, RegWrite, instr, ImmOp,
      output ready_out, result, result_valid, EQ, a0
   );
endinterface

// File: rtl/reg_alu_pipe.sv
// rtl/reg_alu_pipe.sv - two-stage register-file/ALU pipeline with forwarding and iterative multiplier
module reg_alu_pipe #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 5,
   parameter int INSTR_WIDTH   = 32,
   parameter int IMMOP_WIDTH   = 32,
   parameter int CONTROL_WIDTH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   reg_alu_pipe_if.slave bus
);
   localparam int NREG = 2 ** ADDRESS_WIDTH;
   localparam int SHW  = $clog2(DATA_WIDTH);
   localparam logic [ADDRESS_WIDTH-1:0] A0_IDX = ADDRESS_WIDTH'(10);
   localparam logic [SHW-1:0]           MUL_LAST = SHW'(DATA_WIDTH - 1);
   localparam logic [CONTROL_WIDTH-1:0] OP_MUL = CONTROL_WIDTH'(10);

   typedef enum logic {EX_IDLE, EX_RUN} ex_state_e;

   ex_state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0]    rf_q [NREG];
   logic                     ex_wr_q;
   logic [ADDRESS_WIDTH-1:0] ex_rd_q;
   logic [CONTROL_WIDTH-1:0] ex_ctrl_q;
   logic [DATA_WIDTH-1:0]    ex_op1_q, ex_op2_q;
   logic [SHW-1:0]           mul_cnt_q, mul_cnt_d;
   logic [DATA_WIDTH-1:0]    mul_acc_q, mul_acc_d;
   logic [DATA_WIDTH-1:0]    result_q;
   logic                     result_valid_q, eq_q;

   logic [ADDRESS_WIDTH-1:0] rs1, rs2, rd;
   logic [DATA_WIDTH-1:0]    imm_ext, op1, op2, ex_result, mul_sum;
   logic [SHW-1:0]           shamt;
   logic                     ex_final, ready, accept, fwd_ok;
   logic                     unused_instr;

   assign rs1 = bus.instr[15 +: ADDRESS_WIDTH];
   assign rs2 = bus.instr[20 +: ADDRESS_WIDTH];
   assign rd  = bus.instr[7 +: ADDRESS_WIDTH];
   assign unused_instr = ^{bus.instr[INSTR_WIDTH-1:25], bus.instr[14:12], bus.instr[6:0]};

   generate
      if (IMMOP_WIDTH >= DATA_WIDTH) begin : g_imm_trunc
         assign imm_ext = bus.ImmOp[DATA_WIDTH-1:0];
      end else begin : g_imm_zext
         assign imm_ext = {{(DATA_WIDTH - IMMOP_WIDTH){1'b0}}, bus.ImmOp};
      end
   endgenerate

   // A multiply is only retiring once its counter reaches the last bit.
   assign ex_final = (state_q == EX_RUN) && ((ex_ctrl_q != OP_MUL) || (mul_cnt_q == MUL_LAST));
   assign ready    = (state_q == EX_IDLE) || ex_final;
   assign accept   = bus.valid_in && ready;
   assign fwd_ok   = ex_final && ex_wr_q && (ex_rd_q != '0);

   assign op1 = (fwd_ok && rs1 == ex_rd_q) ? ex_result : rf_q[rs1];
   assign op2 = bus.ALUsrc ? imm_ext : ((fwd_ok && rs2 == ex_rd_q) ? ex_result : rf_q[rs2]);

   assign shamt   = ex_op2_q[SHW-1:0];
   assign mul_sum = mul_acc_q + (ex_op2_q[mul_cnt_q] ? (ex_op1_q << mul_cnt_q) : '0);

   always_comb begin
      ex_result = '0;
      case (ex_ctrl_q)
         CONTROL_WIDTH'(0): ex_result = ex_op1_q + ex_op2_q;
         CONTROL_WIDTH'(1): ex_result = ex_op1_q - ex_op2_q;
         CONTROL_WIDTH'(2): ex_result = ex_op1_q & ex_op2_q;
         CONTROL_WIDTH'(3): ex_result = ex_op1_q | ex_op2_q;
         CONTROL_WIDTH'(4): ex_result = ex_op1_q ^ ex_op2_q;
         CONTROL_WIDTH'(5): ex_result = ex_op1_q << shamt;
         CONTROL_WIDTH'(6): ex_result = ex_op1_q >> shamt;
         CONTROL_WIDTH'(7): ex_result = $signed(ex_op1_q) >>> shamt;
         CONTROL_WIDTH'(8): ex_result = {{(DATA_WIDTH-1){1'b0}}, $signed(ex_op1_q) < $signed(ex_op2_q)};
         CONTROL_WIDTH'(9): ex_result = {{(DATA_WIDTH-1){1'b0}}, ex_op1_q < ex_op2_q};
         OP_MUL:            ex_result = mul_sum;
         default:           ex_result = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mul_cnt_d = mul_cnt_q;
      mul_acc_d = mul_acc_q;
      if (accept) begin
         state_d   = EX_RUN;
         mul_cnt_d = '0;
         mul_acc_d = '0;
      end else if (ex_final) begin
         state_d = EX_IDLE;
      end else if (state_q == EX_RUN) begin
         mul_cnt_d = mul_cnt_q + 1'b1;
         mul_acc_d = mul_sum;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= EX_IDLE;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
         ex_wr_q        <= 1'b0;
         ex_rd_q        <= '0;
         ex_ctrl_q      <= '0;
         ex_op1_q       <= '0;
         ex_op2_q       <= '0;
         mul_cnt_q      <= '0;
         mul_acc_q      <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         eq_q           <= 1'b0;
      end else begin
         state_q   <= state_d;
         mul_cnt_q <= mul_cnt_d;
         mul_acc_q <= mul_acc_d;
         if (accept) begin
            ex_wr_q   <= bus.RegWrite;
            ex_rd_q   <= rd;
            ex_ctrl_q <= bus.ALUctrl;
            ex_op1_q  <= op1;
            ex_op2_q  <= op2;
         end
         result_valid_q <= ex_final;
         if (ex_final) begin
            result_q <= ex_result;
            eq_q     <= (ex_op1_q == ex_op2_q);
            if (ex_wr_q && ex_rd_q != '0) rf_q[ex_rd_q] <= ex_result;
         end
      end
   end

   assign bus.ready_out    = ready;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.EQ           = eq_q;
   assign bus.a0           = rf_q[A0_IDX];
endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb/tb_reg_alu_pipe.sv - self-checking bench for reg_alu_pipe against a sequential ISA-level model
module tb_reg_alu_pipe;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   logic [31:0] model_rf [32];
   logic [31:0] exp_res_q [$];
   logic        exp_eq_q [$];

   reg_alu_pipe_if bus ();

   reg_alu_pipe dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input int ctrl, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int          sh;
      sh = int'(b % 32);
      case (ctrl)
         0: r = a + b;
         1: r = a - b;
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = a << sh;
         6: r = a >> sh;
         7: r = $signed(a) >>> sh;
         8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         9: r = (a < b) ? 32'd1 : 32'd0;
         10: r = a * b;
         default: r = 32'd0;
      endcase
      return r;
   endfunction

   task automatic model_issue(input bit src, input int ctrl, input bit wr, input int rd, input int rs1,
                              input int rs2, input logic [31:0] imm, output logic [31:0] res, output logic eq);
      logic [31:0] a, b;
      a   = model_rf[rs1];
      b   = src ? imm : model_rf[rs2];
      res = ref_alu(ctrl, a, b);
      eq  = (a == b);
      if (wr && rd != 0) model_rf[rd] = res;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
   endtask

   task automatic drive(input bit src, input int ctrl, input bit wr, input int rd, input int rs1,
                        input int rs2, input logic [31:0] imm, input logic [31:0] junk);
      logic [31:0] ins;
      ins        = junk;
      ins[24:20] = rs2[4:0];
      ins[19:15] = rs1[4:0];
      ins[11:7]  = rd[4:0];
      bus.instr    = ins;
      bus.ALUsrc   = src;
      bus.ALUctrl  = ctrl[3:0];
      bus.RegWrite = wr;
      bus.ImmOp    = imm;
      bus.valid_in = 1'b1;
   endtask

   task automatic exec(input bit src, input int ctrl, input bit wr, input int rd, input int rs1,
                       input int rs2, input logic [31:0] imm, output logic [31:0] res, output logic eq,
                       output int lat, output int low, output bit got);
      logic [31:0] mres;
      logic        meq;
      int          w;
      model_issue(src, ctrl, wr, rd, rs1, rs2, imm, mres, meq);
      @(negedge clk);
      drive(src, ctrl, wr, rd, rs1, rs2, imm, 32'h0000_0013);
      w = 0;
      while (!bus.ready_out && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      bus.valid_in = 1'b0;
      lat = 1; low = 0; got = 1'b0; res = 'x; eq = 1'bx;
      for (int i = 0; i < 200; i++) begin
         if (!bus.ready_out) low++;
         if (bus.result_valid) begin
            got = 1'b1;
            res = bus.result;
            eq  = bus.EQ;
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      n_vec++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
      n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv: got %b want 0", bus.result_valid); end
      n_vec++; if (bus.EQ !== 1'b0) begin n_err++; $display("FAIL reset_eq: got %b want 0", bus.EQ); end
      n_vec++; if (bus.a0 !== 32'd0) begin n_err++; $display("FAIL reset_a0: got %h want 0", bus.a0); end
      n_vec++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", bus.ready_out); end
   endtask

   task automatic test_addi();
      logic [31:0] r; logic e; int lat, low; bit got;
      exec(1, 0, 1, 10, 0, 0, 32'd5, r, e, lat, low, got);
      n_vec++; if (!got || lat !== 2) begin n_err++; $display("FAIL addi_latency: got %0d (seen %0b) want 2", lat, got); end
      n_vec++; if (r !== 32'd5) begin n_err++; $display("FAIL addi_result: got %h want 5", r); end
      n_vec++; if (bus.a0 !== 32'd5) begin n_err++; $display("FAIL addi_a0: got %h want 5", bus.a0); end
      @(negedge clk);
      n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL addi_pulse: got %b want 0", bus.result_valid); end
      n_vec++; if (bus.a0 !== 32'd5 || bus.result !== 32'd5) begin n_err++; $display("FAIL addi_hold: a0 %h result %h want 5", bus.a0, bus.result); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] mr; logic me;
      @(negedge clk);
      drive(1, 0, 1, 1, 0, 0, 32'd7, 32'h0000_0013);
      model_issue(1, 0, 1, 1, 0, 0, 32'd7, mr, me);
      n_vec++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", bus.ready_out); end
      @(negedge clk);
      n_vec++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", bus.ready_out); end
      drive(0, 0, 1, 2, 1, 1, 32'd0, 32'h0000_0033);
      model_issue(0, 0, 1, 2, 1, 1, 32'd0, mr, me);
      @(negedge clk);
      bus.valid_in = 1'b0;
      n_vec++; if (bus.result_valid !== 1'b1 || bus.result !== 32'd7) begin n_err++; $display("FAIL b2b_first: rv %b result %h want 1/7", bus.result_valid, bus.result); end
      @(negedge clk);
      n_vec++; if (bus.result_valid !== 1'b1 || bus.result !== 32'd14) begin n_err++; $display("FAIL b2b_second: rv %b result %h want 1/14", bus.result_valid, bus.result); end
      @(negedge clk);
      n_vec++; if (bus.result_valid !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got %b want 0", bus.result_valid); end
   endtask

   task automatic test_mul();
      logic [31:0] r, mr; logic e, me; int lat, low, nres; bit got, acc_now;
      logic [31:0] rr [2]; logic ee [2]; int cc [2];
      exec(1, 0, 1, 3, 0, 0, 32'd6, r, e, lat, low, got);
      exec(1, 0, 1, 4, 0, 0, 32'hFFFF_FFFD, r, e, lat, low, got);
      @(negedge clk);
      drive(0, 10, 1, 5, 3, 4, 32'd0, 32'h0000_0033);
      model_issue(0, 10, 1, 5, 3, 4, 32'd0, mr, me);
      @(negedge clk);
      drive(0, 0, 1, 6, 5, 0, 32'd0, 32'h0000_0033);
      model_issue(0, 0, 1, 6, 5, 0, 32'd0, mr, me);
      low = 0; nres = 0; acc_now = 1'b0;
      for (int i = 0; i < 100 && nres < 2; i++) begin
         if (acc_now) begin bus.valid_in = 1'b0; acc_now = 1'b0; end
         if (!bus.ready_out) low++;
         if (bus.result_valid) begin rr[nres] = bus.result; ee[nres] = bus.EQ; cc[nres] = i; nres++; end
         if (bus.valid_in && bus.ready_out) acc_now = 1'b1;
         if (nres < 2) @(negedge clk);
      end
      bus.valid_in = 1'b0;
      n_vec++; if (nres !== 2) begin n_err++; $display("FAIL mul_timeout: got %0d results want 2", nres); end
      n_vec++; if (low !== 31) begin n_err++; $display("FAIL mul_stall: got %0d low cycles want 31", low); end
      if (nres == 2) begin
         n_vec++; if (rr[0] !== 32'hFFFF_FFEE) begin n_err++; $display("FAIL mul_result: got %h want ffffffee", rr[0]); end
         n_vec++; if (ee[0] !== 1'b0) begin n_err++; $display("FAIL mul_eq: got %b want 0", ee[0]); end
         n_vec++; if (rr[1] !== 32'hFFFF_FFEE) begin n_err++; $display("FAIL mul_fwd: got %h want ffffffee", rr[1]); end
         n_vec++; if (cc[1] !== cc[0] + 1) begin n_err++; $display("FAIL mul_fwd_gap: got %0d want %0d", cc[1], cc[0] + 1); end
      end
   endtask

   task automatic test_compare_shift();
      logic [31:0] r; logic e; int lat, low; bit got;
      exec(0, 1, 1, 7, 1, 1, 32'd0, r, e, lat, low, got);
      n_vec++; if (r !== 32'd0 || e !== 1'b1) begin n_err++; $display("FAIL sub_eq: result %h eq %b want 0/1", r, e); end
      exec(1, 0, 1, 11, 0, 0, 32'h8000_0000, r, e, lat, low, got);
      exec(1, 7, 1, 12, 11, 0, 32'd4, r, e, lat, low, got);
      n_vec++; if (r !== 32'hF800_0000) begin n_err++; $display("FAIL sra: got %h want f8000000", r); end
      exec(1, 0, 1, 13, 0, 0, 32'd1, r, e, lat, low, got);
      exec(1, 0, 1, 14, 0, 0, 32'hFFFF_FFFF, r, e, lat, low, got);
      exec(0, 9, 1, 15, 13, 14, 32'd0, r, e, lat, low, got);
      n_vec++; if (r !== 32'd1) begin n_err++; $display("FAIL sltu: got %h want 1", r); end
      exec(0, 8, 1, 15, 13, 14, 32'd0, r, e, lat, low, got);
      n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL slt: got %h want 0", r); end
   endtask

   task automatic test_x0();
      logic [31:0] r; logic e; int lat, low; bit got;
      exec(1, 0, 1, 0, 0, 0, 32'd9, r, e, lat, low, got);
      n_vec++; if (r !== 32'd9) begin n_err++; $display("FAIL x0_addi_result: got %h want 9", r); end
      exec(0, 0, 1, 8, 0, 0, 32'd0, r, e, lat, low, got);
      n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL x0_read: got %h want 0", r); end
   endtask

   task automatic test_reset_mid_mul();
      logic [31:0] r; logic e; int lat, low; bit got, seen;
      exec(1, 0, 1, 9, 0, 0, 32'd123, r, e, lat, low, got);
      @(negedge clk);
      drive(0, 10, 1, 9, 3, 4, 32'd0, 32'h0000_0033);
      @(negedge clk);
      bus.valid_in = 1'b0;
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++; if (bus.ready_out !== 1'b1) begin n_err++; $display("FAIL rstmul_ready: got %b want 1", bus.ready_out); end
      n_vec++; if (bus.a0 !== 32'd0 || bus.result !== 32'd0) begin n_err++; $display("FAIL rstmul_clear: a0 %h result %h want 0", bus.a0, bus.result); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.result_valid) seen = 1'b1;
      end
      n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmul_no_retire: got %b want 0", seen); end
      exec(0, 0, 1, 16, 9, 0, 32'd0, r, e, lat, low, got);
      n_vec++; if (r !== 32'd0) begin n_err++; $display("FAIL rstmul_x9: got %h want 0", r); end
   endtask

   task automatic test_random();
      int issued, cycles, n;
      bit need_new;
      logic [31:0] mr; logic me;
      int src, ctrl, wr, rd, rs1, rs2;
      logic [31:0] imm;
      n = 80; issued = 0; need_new = 1'b1;
      for (cycles = 0; cycles < 6000; cycles++) begin
         @(negedge clk);
         if (bus.result_valid) begin
            if (exp_res_q.size() == 0) begin
               n_vec++; n_err++; $display("FAIL rand_extra: got %h want none", bus.result);
            end else begin
               mr = exp_res_q.pop_front();
               me = exp_eq_q.pop_front();
               n_vec++; if (bus.result !== mr) begin n_err++; $display("FAIL rand_result: got %h want %h", bus.result, mr); end
               n_vec++; if (bus.EQ !== me) begin n_err++; $display("FAIL rand_eq: got %b want %b", bus.EQ, me); end
            end
         end
         if (issued == n && exp_res_q.size() == 0 && !need_new) break;
         if (issued == n && exp_res_q.size() == 0 && bus.valid_in == 1'b0) break;
         if (need_new) begin
            if (issued < n && $urandom_range(0, 3) != 0) begin
               src = int'($urandom_range(0, 1)); ctrl = int'($urandom_range(0, 15));
               wr = ($urandom_range(0, 7) != 0) ? 1 : 0;
               rd = int'($urandom_range(0, 15)); rs1 = int'($urandom_range(0, 15)); rs2 = int'($urandom_range(0, 15));
               imm = $urandom;
               drive(src[0], ctrl, wr[0], rd, rs1, rs2, imm, $urandom);
               need_new = 1'b0;
            end else begin
               bus.valid_in = 1'b0;
            end
         end
         if (bus.valid_in && bus.ready_out) begin
            model_issue(src[0], ctrl, wr[0], rd, rs1, rs2, imm, mr, me);
            exp_res_q.push_back(mr);
            exp_eq_q.push_back(me);
            issued++;
            need_new = 1'b1;
         end
      end
      bus.valid_in = 1'b0;
      n_vec++; if (issued !== n || exp_res_q.size() !== 0) begin n_err++; $display("FAIL rand_timeout: issued %0d pending %0d want %0d/0", issued, exp_res_q.size(), n); end
   endtask

   initial begin
      bus.valid_in = 1'b0; bus.ALUsrc = 1'b0; bus.ALUctrl = '0; bus.RegWrite = 1'b0;
      bus.instr = '0; bus.ImmOp = '0;
      model_reset();
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_addi();
      test_back_to_back();
      test_mul();
      test_compare_shift();
      test_x0();
      test_reset_mid_mul();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
